// File: rtl/bignum_stream_collector.sv
// Captures one multi-word number from a word stream into a local buffer,
// flags zero/one values and exposes the buffer through a registered read port.
module bignum_stream_collector #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          request_in,
    output logic                          trigger_out,
    input  logic [REGISTER_SIZE-1:0]      data_in,
    input  logic                          data_valid_in,
    input  logic [$clog2(NUM_BLOCKS)-1:0] rd_addr_in,
    output logic [REGISTER_SIZE-1:0]      rd_data_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          is_zero_out,
    output logic                          is_one_out,
    output logic                          overrun_out
);

    localparam int AW = $clog2(NUM_BLOCKS);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        COLLECT,
        DONE
    } state_t;

    state_t                   state;
    logic [CW-1:0]            word_count;
    logic                     zero_acc;
    logic                     one_acc;
    logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];
    logic                     wr_en;
    logic                     last_word;
    logic                     first_word;
    logic                     not_one_word;

    // Reset wins over a stream word arriving in the same cycle.
    assign wr_en        = (state == COLLECT) && data_valid_in && !rst_in;
    assign last_word    = (word_count == CW'(NUM_BLOCKS - 1));
    assign first_word   = (word_count == '0);
    assign not_one_word = first_word ? (data_in != REGISTER_SIZE'(1))
                                     : (data_in != '0);

    // Flags are only meaningful once a capture has completed.
    assign is_zero_out = (state == DONE) && zero_acc;
    assign is_one_out  = (state == DONE) && one_acc;

    // Capture control: request handshake, word counting and value flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            word_count  <= '0;
            zero_acc    <= 1'b0;
            one_acc     <= 1'b0;
            trigger_out <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            trigger_out <= 1'b0;
            done_out    <= 1'b0;
            if (data_valid_in && (state != COLLECT)) begin
                overrun_out <= 1'b1;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (request_in) begin
                        state       <= REQUEST;
                        trigger_out <= 1'b1;
                        busy_out    <= 1'b1;
                        word_count  <= '0;
                        zero_acc    <= 1'b1;
                        one_acc     <= 1'b1;
                    end
                end
                REQUEST: begin
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (data_valid_in) begin
                        word_count <= word_count + CW'(1);
                        if (data_in != '0) begin
                            zero_acc <= 1'b0;
                        end
                        if (not_one_word) begin
                            one_acc <= 1'b0;
                        end
                        if (last_word) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Word buffer: one write port fed by the stream, one registered read port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[word_count[AW-1:0]] <= data_in;
        end
        rd_data_out <= mem[rd_addr_in];
    end

endmodule

// File: tb/tb_bignum_stream_collector.sv
// Self-checking bench for bignum_stream_collector: table vectors,
// hand-written reset/overrun sequences and randomized captures.
module tb_bignum_stream_collector;

    localparam int W  = 32;
    localparam int NB = 128;
    localparam int AW = 7;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          request_in;
    logic          trigger_out;
    logic [W-1:0]  data_in;
    logic          data_valid_in;
    logic [AW-1:0] rd_addr_in;
    logic [W-1:0]  rd_data_out;
    logic          busy_out;
    logic          done_out;
    logic          is_zero_out;
    logic          is_one_out;
    logic          overrun_out;

    always #5 clk_in = ~clk_in;

    bignum_stream_collector #(
        .REGISTER_SIZE(W),
        .NUM_BLOCKS   (NB)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .request_in   (request_in),
        .trigger_out  (trigger_out),
        .data_in      (data_in),
        .data_valid_in(data_valid_in),
        .rd_addr_in   (rd_addr_in),
        .rd_data_out  (rd_data_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .is_zero_out  (is_zero_out),
        .is_one_out   (is_one_out),
        .overrun_out  (overrun_out)
    );

    typedef enum int {
        K_ONE, K_ZERO, K_RAMP, K_W0_3, K_HI_ONE, K_W1_ONE, K_RAND
    } kind_t;

    typedef struct {
        kind_t        kind;
        int           gaps;
        bit           hold;
        bit           ez;
        bit           eo;
        logic [W-1:0] e5;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] cur   [NB];
    logic [W-1:0] mem_m [NB];
    bit           mem_known = 0;
    vec_t         tbl [9];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gen(kind_t k, int i);
        logic [W-1:0] v;
        v = '0;
        case (k)
            K_ONE:    v = (i == 0) ? 32'd1 : 32'd0;
            K_ZERO:   v = 32'd0;
            K_RAMP:   v = W'(i) * 32'h01010101;
            K_W0_3:   v = (i == 0) ? 32'd3 : 32'd0;
            K_HI_ONE: v = (i == 0 || i == NB - 1) ? 32'd1 : 32'd0;
            K_W1_ONE: v = (i == 1) ? 32'd1 : 32'd0;
            default: begin
                if (i == 0)
                    v = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
                else
                    v = ($urandom_range(0, 15) == 0) ? $urandom : 32'd0;
            end
        endcase
        return v;
    endfunction

    task automatic fill(input kind_t k);
        for (int i = 0; i < NB; i++) cur[i] = gen(k, i);
    endtask

    // Reference: assemble the whole number and compare it as an integer.
    task automatic model_flags(output bit ez, output bit eo);
        logic [W*NB-1:0] num;
        for (int i = 0; i < NB; i++) num[i*W +: W] = cur[i];
        ez = (num == '0);
        eo = (num == (W*NB)'(1));
    endtask

    task automatic scan(inout int t, inout int b);
        if (trigger_out) t++;
        if (done_out || !busy_out || is_zero_out || is_one_out) b++;
    endtask

    task automatic capture(input int gaps, input bit hold, input bit ez,
                           input bit eo, input logic [W-1:0] e5);
        int trig = 0;
        int bad  = 0;
        int rw   = 0;
        int a;
        bit g;
        request_in    = 1'b1;
        data_valid_in = 1'b0;
        tick();
        chk("trigger_req", trigger_out, 1);
        chk("busy_req", busy_out, 1);
        chk("flags_req", {is_zero_out, is_one_out}, 0);
        request_in = hold;
        tick();
        scan(trig, bad);
        for (int i = 0; i < NB; i++) begin
            g = (gaps == 1) || (gaps == 2 && $urandom_range(0, 1) == 1);
            if (g) begin
                data_valid_in = 1'b0;
                data_in       = $urandom;
                tick();
                scan(trig, bad);
            end
            if (i == NB - 1) request_in = 1'b0;
            data_in       = cur[i];
            data_valid_in = 1'b1;
            rd_addr_in    = AW'(i);
            tick();
            data_valid_in = 1'b0;
            if (mem_known && rd_data_out !== mem_m[i]) rw++;
            if (i < NB - 1) scan(trig, bad);
        end
        chk("done_pulse", done_out, 1);
        chk("busy_done", busy_out, 0);
        chk("trig_collect", trig, 0);
        chk("collect_outs", bad, 0);
        chk("is_zero", is_zero_out, ez);
        chk("is_one", is_one_out, eo);
        if (mem_known) chk("rw_old_data", rw, 0);
        for (int i = 0; i < NB; i++) mem_m[i] = cur[i];
        mem_known = 1;
        tick();
        chk("done_once", done_out, 0);
        chk("flags_hold", {is_zero_out, is_one_out}, {ez, eo});
        rd_addr_in = AW'(5);
        tick();
        tick();
        chk("rd_addr5", rd_data_out, e5);
        for (int k = 0; k < 4; k++) begin
            a          = $urandom_range(0, NB - 1);
            rd_addr_in = AW'(a);
            tick();
            chk("rd_rand", rd_data_out, mem_m[a]);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit   ez;
        bit   eo;
        int   kk;
        tbl[0] = '{K_ONE,    0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[1] = '{K_ZERO,   0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2] = '{K_RAMP,   0, 1'b0, 1'b0, 1'b0, 32'h05050505};
        tbl[3] = '{K_ONE,    1, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[4] = '{K_RAMP,   1, 1'b1, 1'b0, 1'b0, 32'h05050505};
        tbl[5] = '{K_W0_3,   0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{K_HI_ONE, 0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{K_W1_ONE, 0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{K_ZERO,   2, 1'b1, 1'b1, 1'b0, 32'h0};

        rst_in        = 1'b1;
        request_in    = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        rd_addr_in    = '0;
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_trigger", trigger_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_zero", is_zero_out, 0);
        chk("rst_one", is_one_out, 0);
        chk("rst_overrun", overrun_out, 0);

        data_valid_in = 1'b1;
        data_in       = 32'hA5A5A5A5;
        tick();
        data_valid_in = 1'b0;
        chk("ovr_idle", overrun_out, 1);
        chk("ovr_idle_busy", busy_out, 0);
        chk("ovr_idle_trig", trigger_out, 0);
        tick();
        tick();
        chk("ovr_sticky", overrun_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("ovr_rst", overrun_out, 0);

        for (int v = 0; v < 9; v++) begin
            fill(tbl[v].kind);
            capture(tbl[v].gaps, tbl[v].hold, tbl[v].ez, tbl[v].eo, tbl[v].e5);
        end

        rd_addr_in    = '0;
        data_valid_in = 1'b1;
        data_in       = 32'hDEADBEEF;
        tick();
        data_valid_in = 1'b0;
        chk("ovr_done", overrun_out, 1);
        chk("ovr_done_flags", {is_zero_out, is_one_out}, {tbl[8].ez, tbl[8].eo});
        tick();
        chk("ovr_no_write", rd_data_out, mem_m[0]);
        fill(K_RAMP);
        capture(0, 1'b0, 1'b0, 1'b0, 32'h05050505);
        chk("ovr_after_cap", overrun_out, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("ovr_cleared", overrun_out, 0);

        for (int i = 0; i < NB; i++) cur[i] = $urandom;
        request_in = 1'b1;
        tick();
        request_in = 1'b0;
        tick();
        for (int i = 0; i < 60; i++) begin
            data_in       = cur[i];
            data_valid_in = 1'b1;
            tick();
            mem_m[i] = cur[i];
        end
        rst_in        = 1'b1;
        request_in    = 1'b1;
        data_valid_in = 1'b1;
        data_in       = $urandom;
        tick();
        chk("abort_busy", busy_out, 0);
        chk("abort_trig", trigger_out, 0);
        chk("abort_done", done_out, 0);
        rst_in        = 1'b0;
        request_in    = 1'b0;
        data_valid_in = 1'b0;
        tick();
        chk("abort_idle", busy_out, 0);
        chk("abort_ovr", overrun_out, 0);
        fill(K_RAND);
        model_flags(ez, eo);
        capture(0, 1'b0, ez, eo, cur[5]);

        for (int r = 0; r < 5; r++) begin
            kk = $urandom_range(0, 2);
            fill(kk == 0 ? K_ONE : (kk == 1 ? K_ZERO : K_RAND));
            model_flags(ez, eo);
            capture($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    ez, eo, cur[5]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
